// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor.
// Processes DIGIT bits per clock, least significant digit first, so a full
// WIDTH-bit operation takes WIDTH/DIGIT cycles followed by a one-cycle done.
module serial_addsub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int K     = WIDTH / DIGIT;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(K - 1);
    localparam logic [WIDTH-1:0] DIGIT_MASK = WIDTH'({DIGIT{1'b1}});

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic              take;
    logic              last;

    // Operands captured at the accepted start; the inputs are free afterwards.
    logic [WIDTH-1:0]  a_p0;
    logic [WIDTH-1:0]  b_p0;
    logic              sub_p0;

    // Running state of the serial computation.
    logic [CNT_W-1:0]  cnt_p0;
    logic              carry_p0;

    logic [31:0]       base;
    logic [DIGIT-1:0]  a_dig;
    logic [DIGIT-1:0]  bx_dig;
    logic [DIGIT-1:0]  s_dig;
    logic              c_dig;
    logic              c_msb_in;
    logic [WIDTH-1:0]  res_nxt;

    // One digit of a + (b ^ mask) + cin; returns {carry_out, sum}.
    function automatic logic [DIGIT:0] digit_add(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             cin
    );
        return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
    endfunction

    // Signed overflow: the carry into the MSB differs from the carry out of it.
    function automatic logic signed_ovf(
        input logic msb_x,
        input logic msb_y,
        input logic msb_s,
        input logic cout
    );
        return (msb_x ^ msb_y ^ msb_s) ^ cout;
    endfunction

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        take      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    take      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_p0 == LAST_DIGIT) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    take      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Digit datapath: select digit i, add, and splice the sum back into result.
    always_comb begin
        base     = 32'(cnt_p0) * 32'(DIGIT);
        a_dig    = DIGIT'(a_p0 >> base);
        bx_dig   = DIGIT'(b_p0 >> base) ^ {DIGIT{sub_p0}};
        {c_dig, s_dig} = digit_add(a_dig, bx_dig, carry_p0);
        c_msb_in = s_dig[DIGIT-1] ^ a_dig[DIGIT-1] ^ bx_dig[DIGIT-1];
        res_nxt  = (result & ~(DIGIT_MASK << base)) | (WIDTH'(s_dig) << base);
        last     = (cnt_p0 == LAST_DIGIT);
    end

    // Operand capture; no reset needed since these are only read during RUN.
    always_ff @(posedge clk) begin
        if (take) begin
            a_p0   <= a;
            b_p0   <= b;
            sub_p0 <= sub;
        end
    end

    // Digit counter, carry chain, result and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p0   <= '0;
            carry_p0 <= 1'b0;
            result   <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (take) begin
            cnt_p0   <= '0;
            carry_p0 <= sub;
        end else if (busy) begin
            cnt_p0   <= cnt_p0 + CNT_W'(1);
            carry_p0 <= c_dig;
            result   <= res_nxt;
            if (last) begin
                c_out    <= c_dig;
                overflow <= signed_ovf(a_dig[DIGIT-1], bx_dig[DIGIT-1],
                                       s_dig[DIGIT-1], c_dig);
                zero     <= (res_nxt == '0);
            end
        end
    end

    // Kept for readability of waveforms: carry into the MSB on the last digit.
    logic unused_c_msb_in;
    assign unused_c_msb_in = c_msb_in;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: 32-bit DIGIT=4 main instance, a DIGIT
// sweep (1, 8, 32) and an exhaustive 4-bit/2-digit instance.
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start_sw = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        busy, done, c_out, overflow, zero;
    logic [31:0] result;

    logic        busy_s [3];
    logic        done_s [3];
    logic [31:0] res_s  [3];
    logic        c_s    [3];
    logic        o_s    [3];
    logic        z_s    [3];

    logic        start4 = 1'b0;
    logic        sub4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        busy4, done4, c4, o4, z4;
    logic [3:0]  res4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(32), .DIGIT(4)) u_main (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .c_out(c_out),
        .overflow(overflow), .zero(zero));

    serial_addsub #(.WIDTH(32), .DIGIT(1)) u_d1 (
        .clk(clk), .reset(reset), .start(start_sw), .sub(sub), .a(a), .b(b),
        .busy(busy_s[0]), .done(done_s[0]), .result(res_s[0]), .c_out(c_s[0]),
        .overflow(o_s[0]), .zero(z_s[0]));

    serial_addsub #(.WIDTH(32), .DIGIT(8)) u_d8 (
        .clk(clk), .reset(reset), .start(start_sw), .sub(sub), .a(a), .b(b),
        .busy(busy_s[1]), .done(done_s[1]), .result(res_s[1]), .c_out(c_s[1]),
        .overflow(o_s[1]), .zero(z_s[1]));

    serial_addsub #(.WIDTH(32), .DIGIT(32)) u_d32 (
        .clk(clk), .reset(reset), .start(start_sw), .sub(sub), .a(a), .b(b),
        .busy(busy_s[2]), .done(done_s[2]), .result(res_s[2]), .c_out(c_s[2]),
        .overflow(o_s[2]), .zero(z_s[2]));

    serial_addsub #(.WIDTH(4), .DIGIT(2)) u_w4 (
        .clk(clk), .reset(reset), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(res4), .c_out(c4),
        .overflow(o4), .zero(z4));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] r;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    vec_t tv [10];

    // Reference built from true signed/unsigned arithmetic, not carry chains.
    function automatic logic [34:0] ref32(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        longint      t  = s ? (sx - sy) : (sx + sy);
        logic [31:0] r  = s ? (x - y) : (x + y);
        logic        c  = s ? (x >= y) : (({1'b0, x} + {1'b0, y}) > 33'h0FFFFFFFF);
        logic        o  = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        return {r, c, o, (r == 32'd0)};
    endfunction

    function automatic logic [6:0] ref4(input logic [3:0] x, input logic [3:0] y,
                                        input logic s);
        int         sx = int'($signed(x));
        int         sy = int'($signed(y));
        int         t  = s ? (sx - sy) : (sx + sy);
        logic [3:0] r  = s ? (x - y) : (x + y);
        logic       c  = s ? (x >= y) : ((int'(x) + int'(y)) > 15);
        logic       o  = (t > 7) || (t < -8);
        return {r, c, o, (r == 4'd0)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Start one op on the main DUT, scramble inputs after the start edge,
    // return the cycle (counting from the start-drive cycle) where done shows.
    task automatic run_main(input logic [31:0] xa, input logic [31:0] xb, input logic xs,
                            output int lat, output int bcnt);
        a = xa; b = xb; sub = xs; start = 1'b1;
        lat = -1; bcnt = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                start = 1'b0;
                a = ~xa; b = xb ^ 32'h5A5A_A5A5; sub = ~xs;
            end
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    logic [34:0] sw_got [3];
    int          sw_bc  [3];

    task automatic run_sw(input logic [31:0] xa, input logic [31:0] xb, input logic xs);
        a = xa; b = xb; sub = xs; start_sw = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sw_got[k] = 'x;
            sw_bc[k]  = 0;
        end
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (n == 1) start_sw = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (busy_s[k]) sw_bc[k]++;
                if (done_s[k]) sw_got[k] = {res_s[k], c_s[k], o_s[k], z_s[k]};
            end
            if (done_s[0]) break;
        end
    endtask

    initial begin
        int          lat, bc, lat2, bc2, nd, seen;
        logic [31:0] held;
        logic [34:0] exp35;
        logic [6:0]  exp7;
        logic [31:0] ra, rb;
        logic        rs;
        int          sw_k [3];

        sw_k[0] = 32; sw_k[1] = 4; sw_k[2] = 1;

        tv[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
        tv[1] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tv[2] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        tv[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        tv[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tv[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        tv[6] = '{32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 32'h1010_1010, 1'b0, 1'b0, 1'b0};
        tv[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tv[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        tv[9] = '{32'h0000_0001, 32'h8000_0000, 1'b1, 32'h8000_0001, 1'b0, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("reset_main", 64'({busy, done, result, c_out, overflow, zero}), 64'd0);
        chk("reset_w4", 64'({busy4, done4, res4, c4, o4, z4}), 64'd0);

        // Main table on DIGIT=4, with one idle cycle after each done.
        for (int i = 0; i < 10; i++) begin
            run_main(tv[i].a, tv[i].b, tv[i].s, lat, bc);
            chk($sformatf("latency[%0d]", i), 64'(lat), 64'd9);
            chk($sformatf("busy_cycles[%0d]", i), 64'(bc), 64'd8);
            chk($sformatf("result_flags[%0d]", i),
                64'({result, c_out, overflow, zero}),
                64'({tv[i].r, tv[i].c, tv[i].o, tv[i].z}));
            held = result;
            @(posedge clk); #1;
            chk($sformatf("done_pulse_hold[%0d]", i), 64'({done, busy, result}),
                64'({1'b0, 1'b0, tv[i].r}));
        end

        // Start during RUN is ignored.
        a = 32'h0000_0100; b = 32'h0000_0020; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(nd);
        chk("ignore_start_timing", 64'(nd), 64'd5);
        chk("ignore_start_result", 64'({result, c_out, overflow, zero}),
            64'({32'h0000_0120, 1'b0, 1'b0, 1'b0}));
        @(posedge clk); #1;
        chk("ignore_start_no_requeue", 64'({busy, done}), 64'd0);

        // Back-to-back: second start issued in the DONE cycle of the first.
        run_main(32'h0000_0010, 32'h0000_0001, 1'b1, lat, bc);
        run_main(32'h0000_0002, 32'h0000_0002, 1'b0, lat2, bc2);
        chk("b2b_first_latency", 64'(lat), 64'd9);
        chk("b2b_second_latency", 64'(lat2), 64'd9);
        chk("b2b_second_result", 64'({result, c_out, overflow, zero}),
            64'({32'h0000_0004, 1'b0, 1'b0, 1'b0}));
        @(posedge clk); #1;

        // Reset four cycles into RUN abandons the operation.
        a = 32'h1111_1111; b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("midrun_reset_state", 64'({busy, done, result, c_out, overflow, zero}), 64'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("midrun_reset_no_done", 64'(seen), 64'd0);
        run_main(32'h1111_1111, 32'h1111_1111, 1'b0, lat, bc);
        chk("after_reset_latency", 64'(lat), 64'd9);
        chk("after_reset_result", 64'({result, c_out, overflow, zero}),
            64'({32'h2222_2222, 1'b0, 1'b0, 1'b0}));
        @(posedge clk); #1;

        // Reset dominates a simultaneous start.
        a = 32'h0000_0001; b = 32'h0000_0001; sub = 1'b0;
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1; reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("reset_over_start", 64'({busy, done, result}), 64'd0);

        // DIGIT sweep: table vectors then random operands.
        for (int i = 0; i < 26; i++) begin
            if (i < 10) begin
                ra = tv[i].a; rb = tv[i].b; rs = tv[i].s;
                exp35 = {tv[i].r, tv[i].c, tv[i].o, tv[i].z};
            end else begin
                ra = $urandom; rb = $urandom; rs = 1'($urandom_range(1, 0));
                if (i == 10) begin ra = 32'h7FFF_FFFF; rb = 32'h8000_0000; rs = 1'b1; end
                exp35 = ref32(ra, rb, rs);
            end
            run_sw(ra, rb, rs);
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("sweep_digit%0d_res[%0d]", 32 / sw_k[k], i),
                    64'(sw_got[k]), 64'(exp35));
                chk($sformatf("sweep_digit%0d_busy[%0d]", 32 / sw_k[k], i),
                    64'(sw_bc[k]), 64'(sw_k[k]));
            end
        end

        // Exhaustive 4-bit, 2-bit digits, both modes.
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    a4 = 4'(x); b4 = 4'(y); sub4 = 1'(s); start4 = 1'b1;
                    @(posedge clk); #1; start4 = 1'b0;
                    nd = 0;
                    while (!done4 && nd < 10) begin
                        @(posedge clk); #1;
                        nd++;
                    end
                    exp7 = ref4(4'(x), 4'(y), 1'(s));
                    chk($sformatf("w4 %0d %s %0d", x, (s != 0) ? "-" : "+", y),
                        64'({done4, res4, c4, o4, z4}), 64'({1'b1, exp7}));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
